// File: rtl/kbd_cmd_seq_if.sv
// Byte-level link between the command sequencer and the PS/2 interface:
// transmit handshake plus the received-byte stream.
interface kbd_cmd_seq_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_done;
    logic       tx_err;
    logic [7:0] scode;
    logic       scode_en;

    modport master (
        output tx_data, tx_start,
        input  tx_done, tx_err, scode, scode_en
    );

    modport slave (
        input  tx_data, tx_start,
        output tx_done, tx_err, scode, scode_en
    );
endinterface

// File: rtl/kbd_cmd_seq.sv
// Host-to-keyboard command sequencer: queues reset/LED/typematic requests,
// sends their byte lists with ACK/RESEND retry, and forwards unused scancodes.
module kbd_cmd_seq #(
    parameter logic [25:0] P_ACK_TMO   = 26'd1_000_000,
    parameter logic [25:0] P_BAT_TMO   = 26'd50_000_000,
    parameter logic [1:0]  P_MAX_RETRY = 2'd3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_rst,
    input  logic          req_led,
    input  logic [2:0]    led,
    input  logic          req_rate,
    input  logic [7:0]    rate,
    kbd_cmd_seq_if.master kbd,
    output logic [7:0]    fwd_code,
    output logic          fwd_en,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code
);

    typedef enum logic [2:0] {
        S_IDLE, S_SEND, S_WAIT_TX, S_WAIT_ACK, S_RETRY, S_WAIT_BAT, S_DONE, S_ERR
    } state_t;

    typedef enum logic [1:0] {CMD_RST, CMD_LED, CMD_RATE} cmd_t;

    state_t      state, state_next;
    cmd_t        cmd, grant_cmd;
    logic        pend_rst, pend_led, pend_rate;
    logic [2:0]  led_arg;
    logic [7:0]  rate_arg, cur_arg, cur_byte;
    logic        idx;
    logic [1:0]  retry;
    logic [25:0] timer;
    logic [1:0]  err_code_next;
    logic        grant, last_byte, consumed;
    logic        rx_ack, rx_resend, rx_bat_ok, rx_bat_fail;

    assign grant       = (state == S_IDLE) && (pend_rst || pend_led || pend_rate);
    assign last_byte   = (cmd == CMD_RST) || idx;
    assign rx_ack      = kbd.scode_en && (kbd.scode == 8'hFA);
    assign rx_resend   = kbd.scode_en && (kbd.scode == 8'hFE);
    assign rx_bat_ok   = kbd.scode_en && (kbd.scode == 8'hAA);
    assign rx_bat_fail = kbd.scode_en && (kbd.scode == 8'hFC);
    assign consumed    = ((state == S_WAIT_ACK) && (rx_ack || rx_resend)) ||
                         ((state == S_WAIT_BAT) && (rx_bat_ok || rx_bat_fail));

    always_comb begin
        if (pend_rst)      grant_cmd = CMD_RST;
        else if (pend_led) grant_cmd = CMD_LED;
        else               grant_cmd = CMD_RATE;
    end

    always_comb begin
        case (cmd)
            CMD_RST: cur_byte = 8'hFF;
            CMD_LED: cur_byte = idx ? cur_arg : 8'hED;
            default: cur_byte = idx ? cur_arg : 8'hF3;
        endcase
    end

    // A request in the same cycle as its grant keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_rst  <= 1'b0;
            pend_led  <= 1'b0;
            pend_rate <= 1'b0;
            led_arg   <= 3'd0;
            rate_arg  <= 8'd0;
        end else begin
            if (req_rst)
                pend_rst <= 1'b1;
            else if (grant && grant_cmd == CMD_RST)
                pend_rst <= 1'b0;
            if (req_led) begin
                pend_led <= 1'b1;
                led_arg  <= led;
            end else if (grant && grant_cmd == CMD_LED) begin
                pend_led <= 1'b0;
            end
            if (req_rate) begin
                pend_rate <= 1'b1;
                rate_arg  <= rate;
            end else if (grant && grant_cmd == CMD_RATE) begin
                pend_rate <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next    = state;
        err_code_next = err_code;
        case (state)
            S_IDLE:    if (grant) state_next = S_SEND;
            S_SEND:    state_next = S_WAIT_TX;
            S_WAIT_TX: begin
                if (kbd.tx_done)     state_next = S_WAIT_ACK;
                else if (kbd.tx_err) state_next = S_RETRY;
            end
            S_WAIT_ACK: begin
                if (rx_ack) begin
                    if (!last_byte)          state_next = S_SEND;
                    else if (cmd == CMD_RST) state_next = S_WAIT_BAT;
                    else                     state_next = S_DONE;
                end else if (rx_resend || timer >= P_ACK_TMO) begin
                    state_next = S_RETRY;
                end
            end
            S_RETRY: begin
                if (retry == P_MAX_RETRY) begin
                    state_next    = S_ERR;
                    err_code_next = 2'd1;
                end else begin
                    state_next = S_SEND;
                end
            end
            S_WAIT_BAT: begin
                if (rx_bat_ok) begin
                    state_next = S_DONE;
                end else if (rx_bat_fail) begin
                    state_next    = S_ERR;
                    err_code_next = 2'd2;
                end else if (timer >= P_BAT_TMO) begin
                    state_next    = S_ERR;
                    err_code_next = 2'd3;
                end
            end
            S_DONE:    state_next = S_IDLE;
            S_ERR:     state_next = S_IDLE;
        endcase
    end

    always_comb begin
        kbd.tx_start = (state == S_SEND);
        kbd.tx_data  = (state == S_SEND) ? cur_byte : 8'h00;
        busy         = (state != S_IDLE);
        done         = (state == S_DONE);
        err          = (state == S_ERR);
    end

    // The argument is frozen at grant so later requests cannot alter a sequence in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd      <= CMD_RST;
            cur_arg  <= 8'd0;
            idx      <= 1'b0;
            retry    <= 2'd0;
            timer    <= 26'd0;
            err_code <= 2'd0;
            fwd_code <= 8'd0;
            fwd_en   <= 1'b0;
        end else begin
            err_code <= err_code_next;
            if (grant) begin
                cmd   <= grant_cmd;
                idx   <= 1'b0;
                retry <= 2'd0;
                case (grant_cmd)
                    CMD_LED:  cur_arg <= {5'b0, led_arg};
                    CMD_RATE: cur_arg <= rate_arg;
                    default:  cur_arg <= 8'h00;
                endcase
            end
            if (state == S_WAIT_ACK && rx_ack) begin
                idx   <= idx + 1'b1;
                retry <= 2'd0;
            end
            if (state == S_RETRY && retry != P_MAX_RETRY)
                retry <= retry + 2'd1;
            if ((state_next == S_WAIT_ACK && state != S_WAIT_ACK) ||
                (state_next == S_WAIT_BAT && state != S_WAIT_BAT))
                timer <= 26'd0;
            else if ((state == S_WAIT_ACK || state == S_WAIT_BAT) && timer != 26'h3FF_FFFF)
                timer <= timer + 26'd1;
            fwd_en <= kbd.scode_en && !consumed;
            if (kbd.scode_en && !consumed)
                fwd_code <= kbd.scode;
        end
    end

endmodule

// File: tb/tb_kbd_cmd_seq.sv
// Directed bench for kbd_cmd_seq: a scripted keyboard answers each byte and
// every result is compared against hand-computed values.
module tb_kbd_cmd_seq;

    localparam logic [25:0] ACK_TMO = 26'd300;
    localparam logic [25:0] BAT_TMO = 26'd3000;

    logic       clk;
    logic       rst_n;
    logic       req_rst, req_led, req_rate;
    logic [2:0] led;
    logic [7:0] rate;
    logic [7:0] fwd_code;
    logic       fwd_en, busy, done, err;
    logic [1:0] err_code;

    int compared   = 0;
    int mismatched = 0;
    int tx_cnt = 0, done_cnt = 0, err_cnt = 0, fwd_cnt = 0;
    int t_tx, t_done, t_err, t_fwd;
    logic gd, ge;
    int cyc;

    kbd_cmd_seq_if kbd ();

    kbd_cmd_seq #(
        .P_ACK_TMO   (ACK_TMO),
        .P_BAT_TMO   (BAT_TMO),
        .P_MAX_RETRY (2'd3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_rst  (req_rst),
        .req_led  (req_led),
        .led      (led),
        .req_rate (req_rate),
        .rate     (rate),
        .kbd      (kbd.master),
        .fwd_code (fwd_code),
        .fwd_en   (fwd_en),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (kbd.tx_start) tx_cnt++;
        if (done)         done_cnt++;
        if (err)          err_cnt++;
        if (fwd_en)       fwd_cnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // reqs = {rst, led, rate}
    task automatic applyStimulus(input logic [2:0] reqs, input logic [2:0] led_v, input logic [7:0] rate_v);
        req_rst  = reqs[2];
        req_led  = reqs[1];
        req_rate = reqs[0];
        led      = led_v;
        rate     = rate_v;
        @(negedge clk);
        req_rst  = 1'b0;
        req_led  = 1'b0;
        req_rate = 1'b0;
    endtask

    task automatic expect_tx(input string tag, input logic [7:0] exp_byte, input bit do_ack);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (kbd.tx_start) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput(tag, seen ? {24'h0, kbd.tx_data} : 32'hFFFF_FFFF, {24'h0, exp_byte});
        if (seen && do_ack) begin
            @(negedge clk);
            kbd.tx_done = 1'b1;
            @(negedge clk);
            kbd.tx_done = 1'b0;
        end
    endtask

    task automatic send_code(input logic [7:0] code);
        kbd.scode    = code;
        kbd.scode_en = 1'b1;
        @(negedge clk);
        kbd.scode_en = 1'b0;
    endtask

    task automatic wait_end(input int limit, output logic got_done, output logic got_err, output int cycles);
        got_done = 1'b0;
        got_err  = 1'b0;
        cycles   = 0;
        for (int i = 0; i < limit; i++) begin
            if (done) begin got_done = 1'b1; break; end
            if (err)  begin got_err  = 1'b1; break; end
            @(negedge clk);
            cycles++;
        end
        @(negedge clk);
    endtask

    task automatic snap();
        t_tx = tx_cnt; t_done = done_cnt; t_err = err_cnt; t_fwd = fwd_cnt;
    endtask

    initial begin
        rst_n = 1'b0;
        req_rst = 1'b0; req_led = 1'b0; req_rate = 1'b0;
        led = 3'd0; rate = 8'd0;
        kbd.tx_done = 1'b0; kbd.tx_err = 1'b0;
        kbd.scode = 8'd0; kbd.scode_en = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy",     busy, 0);
        checkOutput("reset tx_start", kbd.tx_start, 0);
        checkOutput("reset tx_data",  kbd.tx_data, 0);
        checkOutput("reset done/err", {done, err}, 0);
        checkOutput("reset fwd",      {fwd_en, fwd_code}, 0);
        checkOutput("reset err_code", err_code, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // LED set: ED then 05
        snap();
        applyStimulus(3'b010, 3'b101, 8'h00);
        expect_tx("t1 byte0", 8'hED, 1);
        checkOutput("t1 busy", busy, 1);
        send_code(8'hFA);
        checkOutput("t1 FA not fwd", fwd_en, 0);
        expect_tx("t1 byte1", 8'h05, 1);
        checkOutput("t1 busy2", busy, 1);
        send_code(8'hFA);
        wait_end(20, gd, ge, cyc);
        checkOutput("t1 done", gd, 1);
        repeat (3) @(negedge clk);
        checkOutput("t1 tx count",   tx_cnt - t_tx, 2);
        checkOutput("t1 done count", done_cnt - t_done, 1);
        checkOutput("t1 fwd count",  fwd_cnt - t_fwd, 0);
        checkOutput("t1 idle busy",  busy, 0);

        // Reset with BAT pass, BAT fail, BAT timeout
        snap();
        applyStimulus(3'b100, 3'b000, 8'h00);
        expect_tx("t2a FF", 8'hFF, 1);
        send_code(8'hFA);
        repeat (1000) @(negedge clk);
        checkOutput("t2a busy in bat", busy, 1);
        send_code(8'hAA);
        wait_end(20, gd, ge, cyc);
        checkOutput("t2a done", gd, 1);
        checkOutput("t2a fwd count", fwd_cnt - t_fwd, 0);

        applyStimulus(3'b100, 3'b000, 8'h00);
        expect_tx("t2b FF", 8'hFF, 1);
        send_code(8'hFA);
        repeat (10) @(negedge clk);
        send_code(8'hFC);
        wait_end(20, gd, ge, cyc);
        checkOutput("t2b err", ge, 1);
        checkOutput("t2b err_code", err_code, 2);

        applyStimulus(3'b100, 3'b000, 8'h00);
        expect_tx("t2c FF", 8'hFF, 1);
        send_code(8'hFA);
        wait_end(BAT_TMO + 200, gd, ge, cyc);
        checkOutput("t2c err", ge, 1);
        checkOutput("t2c err_code", err_code, 3);
        checkOutput("t2c tmo window", (cyc >= int'(BAT_TMO)) && (cyc <= int'(BAT_TMO) + 2), 1);

        // Typematic with two resends, then with retries exhausted
        snap();
        applyStimulus(3'b001, 3'b000, 8'h20);
        expect_tx("t3a F3 #0", 8'hF3, 1);
        send_code(8'hFE);
        expect_tx("t3a F3 #1", 8'hF3, 1);
        send_code(8'hFE);
        expect_tx("t3a F3 #2", 8'hF3, 1);
        send_code(8'hFA);
        expect_tx("t3a arg", 8'h20, 1);
        send_code(8'hFA);
        wait_end(20, gd, ge, cyc);
        checkOutput("t3a done", gd, 1);
        checkOutput("t3a tx count", tx_cnt - t_tx, 4);
        checkOutput("t3a fwd count", fwd_cnt - t_fwd, 0);

        snap();
        applyStimulus(3'b001, 3'b000, 8'h20);
        for (int k = 0; k < 4; k++) begin
            expect_tx($sformatf("t3b F3 #%0d", k), 8'hF3, 1);
            send_code(8'hFE);
        end
        wait_end(20, gd, ge, cyc);
        checkOutput("t3b err", ge, 1);
        checkOutput("t3b err_code", err_code, 1);
        repeat (50) @(negedge clk);
        checkOutput("t3b tx count", tx_cnt - t_tx, 4);

        // Simultaneous requests: rst, led, rate order
        snap();
        applyStimulus(3'b111, 3'b011, 8'h4A);
        expect_tx("t4 first FF", 8'hFF, 1);
        send_code(8'hFA);
        send_code(8'hAA);
        wait_end(20, gd, ge, cyc);
        checkOutput("t4 rst done", gd, 1);
        expect_tx("t4 first ED", 8'hED, 1);
        send_code(8'hFA);
        expect_tx("t4 led arg", 8'h03, 1);
        send_code(8'hFA);
        wait_end(20, gd, ge, cyc);
        checkOutput("t4 led done", gd, 1);
        expect_tx("t4 first F3", 8'hF3, 1);
        send_code(8'hFA);
        expect_tx("t4 rate arg", 8'h4A, 1);
        send_code(8'hFA);
        wait_end(20, gd, ge, cyc);
        checkOutput("t4 rate done", gd, 1);
        checkOutput("t4 done count", done_cnt - t_done, 3);

        // Forwarding during WAIT_ACK and in IDLE
        applyStimulus(3'b010, 3'b001, 8'h00);
        expect_tx("t5 ED", 8'hED, 1);
        send_code(8'h1C);
        checkOutput("t5 fwd 1C", {fwd_en, fwd_code}, {1'b1, 8'h1C});
        send_code(8'hFA);
        checkOutput("t5 FA consumed", fwd_en, 0);
        expect_tx("t5 arg", 8'h01, 1);
        send_code(8'hFA);
        wait_end(20, gd, ge, cyc);
        checkOutput("t5 done", gd, 1);
        repeat (3) @(negedge clk);
        send_code(8'hFA);
        checkOutput("t5 idle FA fwd", {fwd_en, fwd_code}, {1'b1, 8'hFA});

        // Reset while waiting for the transmit handshake
        repeat (3) @(negedge clk);
        snap();
        applyStimulus(3'b010, 3'b111, 8'h00);
        expect_tx("t6 ED", 8'hED, 0);
        @(negedge clk);
        applyStimulus(3'b001, 3'b000, 8'h55);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("t6 rst busy",     busy, 0);
        checkOutput("t6 rst outputs",  {kbd.tx_start, kbd.tx_data, done, err, fwd_en}, 0);
        checkOutput("t6 rst err_code", err_code, 0);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        checkOutput("t6 no more tx",   tx_cnt - t_tx, 1);
        checkOutput("t6 no done/err",  (done_cnt - t_done) + (err_cnt - t_err), 0);
        checkOutput("t6 idle busy",    busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
